// File: rtl/io_output_buffer.sv
// io_output_buffer: 4-phase MMIO capture into a FIFO drained over valid/ready.
// Define IO_OUT_COUNT_EN to add the tx_count pop counter port.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module io_output_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  out_req,
  input  logic [`WORD_SIZE-1:0] io_out,
  output logic                  out_ack,
  output logic                  tx_valid,
  output logic [`WORD_SIZE-1:0] tx_data,
  input  logic                  tx_ready,
  output logic                  full,
  output logic                  empty
`ifdef IO_OUT_COUNT_EN
  ,
  output logic [`WORD_SIZE-1:0] tx_count
`endif
);

  if (DEPTH < 2 || (1 << ADDR_W) != DEPTH) begin : g_bad_cfg
    $error("DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
  end

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t state, state_nx;

  logic [`WORD_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wptr, rptr;
  logic [ADDR_W:0]       count;
  logic                  push, pop;

  // Flags decode straight from the count register, so they never glitch.
  assign full     = count == (ADDR_W+1)'(DEPTH);
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : mem[rptr];
  assign out_ack  = state == ACK;
  assign pop      = tx_valid && tx_ready;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (out_req && !full) begin
          push     = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        if (!out_req) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: tx_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= io_out;
  end

`ifdef IO_OUT_COUNT_EN
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)  tx_count <= '0;
    else if (pop) tx_count <= tx_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_io_output_buffer.sv
// tb_io_output_buffer: vector table plus scoreboarded handshake sequences.
// Pops are checked at the falling edge before the clock edge that takes them.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_io_output_buffer;
  localparam int W = `WORD_SIZE;

  logic         clk = 1'b0;
  logic         areset = 1'b0;
  logic         out_req = 1'b0;
  logic [W-1:0] io_out = '0;
  logic         out_ack;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready = 1'b0;
  logic         full;
  logic         empty;
`ifdef IO_OUT_COUNT_EN
  logic [W-1:0] tx_count;
`endif

  io_output_buffer #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .areset   (areset),
    .out_req  (out_req),
    .io_out   (io_out),
    .out_ack  (out_ack),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .full     (full),
    .empty    (empty)
`ifdef IO_OUT_COUNT_EN
    ,
    .tx_count (tx_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         req;
    logic [W-1:0] d;
    logic         rdy;
    logic         push;
    logic         ack;
    logic         valid;
    logic [W-1:0] data;
    logic         full;
    logic         empty;
  } vec_t;

  vec_t         tbl [7];
  logic [W-1:0] sb [$];
  int           checks = 0;
  int           errors = 0;
  int           pops = 0;
  bit           saw_full = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: score a pop at the falling edge, return 1ns after the rise.
  task automatic cyc();
    @(negedge clk);
    if (areset && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(tx_data), 32'hdead_beef);
      end else begin
        chk("sb_data", 32'(tx_data), 32'(sb.pop_front()));
        pops++;
      end
    end
    @(posedge clk);
    #1;
    if (full) saw_full = 1;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    out_req = 1'b0;
    tx_ready = 1'b0;
    sb.delete();
    pops = 0;
    #3;
    areset = 1'b1;
    cyc();
  endtask

  task automatic send(input logic [W-1:0] w, input int lim);
    bit acked = 0;
    out_req = 1'b1;
    io_out = w;
    for (int i = 0; i < lim && !acked; i++) begin
      cyc();
      if (out_ack) acked = 1;
    end
    chk("send_ack", 32'(acked), 32'd1);
    if (acked) sb.push_back(w);
    out_req = 1'b0;
    cyc();
    chk("ack_drop", 32'(out_ack), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while (!empty && n < 40) begin
      cyc();
      n++;
    end
    tx_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_sb", 32'(sb.size()), 32'd0);
`ifdef IO_OUT_COUNT_EN
    chk("tx_count", 32'(tx_count), 32'(pops));
`endif
  endtask

  initial begin
    int p0;

    tbl[0] = '{1, 16'h0041, 0, 1, 1, 1, 16'h0041, 0, 0};
    tbl[1] = '{1, 16'h0041, 0, 0, 1, 1, 16'h0041, 0, 0};
    tbl[2] = '{0, 16'h0000, 0, 0, 0, 1, 16'h0041, 0, 0};
    tbl[3] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
    tbl[4] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
    tbl[5] = '{1, 16'h0042, 0, 1, 1, 1, 16'h0042, 0, 0};
    tbl[6] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};

    #1;
    chk("rst_ack", 32'(out_ack), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
`ifdef IO_OUT_COUNT_EN
    chk("rst_count", 32'(tx_count), 32'd0);
`endif
    do_reset();

    // Single word and tx_ready-while-empty, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      out_req = tbl[i].req;
      io_out = tbl[i].d;
      tx_ready = tbl[i].rdy;
      cyc();
      if (tbl[i].push) sb.push_back(tbl[i].d);
      chk($sformatf("v%0d_ack", i), 32'(out_ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_valid", i), 32'(tx_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(tbl[i].data));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
    end
    tx_ready = 1'b0;
    out_req = 1'b0;
    cyc();

    // Fill to full, stall the ninth request, free one entry.
    do_reset();
    for (int i = 1; i <= 8; i++) send(W'(i), 3);
    chk("fill_full", 32'(full), 32'd1);
    out_req = 1'b1;
    io_out = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ack", 32'(out_ack), 32'd0);
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("pop_no_push", 32'(out_ack), 32'd0);
    chk("pop_not_full", 32'(full), 32'd0);
    cyc();
    chk("late_ack", 32'(out_ack), 32'd1);
    chk("refull", 32'(full), 32'd1);
    sb.push_back(16'h0009);
    out_req = 1'b0;
    cyc();
    drain();
    chk("fill_pops", 32'(pops), 32'd9);

    // Pointer wrap with the sink always ready.
    do_reset();
    saw_full = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(W'(16'h0100 + i), 3);
    drain();
    chk("wrap_pops", 32'(pops), 32'd20);
    chk("wrap_never_full", 32'(saw_full), 32'd0);

    // Push and pop on the same edge.
    do_reset();
    send(16'h0A01, 3);
    send(16'h0A02, 3);
    send(16'h0A03, 3);
    out_req = 1'b1;
    io_out = 16'h0A04;
    tx_ready = 1'b1;
    cyc();
    sb.push_back(16'h0A04);
    tx_ready = 1'b0;
    chk("pp_ack", 32'(out_ack), 32'd1);
    chk("pp_head", 32'(tx_data), 32'h0A02);
    out_req = 1'b0;
    cyc();
    p0 = pops;
    drain();
    chk("pp_count", 32'(pops - p0), 32'd3);

    // Request held high for ten cycles: one write only.
    do_reset();
    out_req = 1'b1;
    io_out = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("held_ack", 32'(out_ack), 32'd1);
    end
    sb.push_back(16'h00FF);
    out_req = 1'b0;
    cyc();
    chk("held_drop", 32'(out_ack), 32'd0);
    drain();
    chk("held_pops", 32'(pops), 32'd1);

    // Asynchronous reset in the middle of an acknowledge.
    do_reset();
    send(16'h0B01, 3);
    send(16'h0B02, 3);
    out_req = 1'b1;
    io_out = 16'h0B03;
    cyc();
    chk("mid_ack", 32'(out_ack), 32'd1);
    #1;
    areset = 1'b0;
    #1;
    chk("ar_ack", 32'(out_ack), 32'd0);
    chk("ar_valid", 32'(tx_valid), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_data", 32'(tx_data), 32'd0);
`ifdef IO_OUT_COUNT_EN
    chk("ar_count", 32'(tx_count), 32'd0);
`endif
    sb.delete();
    pops = 0;
    #1;
    areset = 1'b1;
    cyc();
    chk("rereq_ack", 32'(out_ack), 32'd1);
    chk("rereq_data", 32'(tx_data), 32'h0B03);
    sb.push_back(16'h0B03);
    out_req = 1'b0;
    cyc();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
